// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB4 requester.
// State encoding and PPROT bit positions.
package apb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SETUP  = ST_SETUP,
      ACCESS = ST_ACCESS
   } apb_state_e;

   localparam int PPROT_PRIV  = 0;
   localparam int PPROT_NSEC  = 1;
   localparam int PPROT_INSTR = 2;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating wait-state counter with clear/enable.
// Ports: pclk, preset, clr, en in; expired out when count == TIMEOUT.
module apb_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic pclk,
   input  logic preset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + CW'(1);
      end
   end

   // A zero TIMEOUT disables the abort entirely.
   assign expired = (TIMEOUT > 0) && (cnt == LIMIT);

endmodule

// File: rtl/apb4_master_ctrl.sv
// apb4_master_ctrl: valid/ready command stream to APB4 requester.
// Ports: cmd_* in, rsp_* out, APB p* bus, state debug out.
module apb4_master_ctrl
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   input  logic [2:0]          cmd_prot,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W/8-1:0] pstrb,
   output logic [2:0]          pprot,
   input  logic                pready,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pslverr,
   output logic [1:0]          state
);

   apb_state_e st;
   logic       tmr_exp;
   logic       tmo_fire;
   logic       done;
   logic       accept;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .pclk    (pclk),
      .preset  (preset),
      .clr     (st == SETUP),
      .en      ((st == ACCESS) && !pready),
      .expired (tmr_exp)
   );

   // pready wins over a timeout landing in the same cycle.
   assign tmo_fire  = (st == ACCESS) && !pready && tmr_exp;
   assign done      = (st == ACCESS) && (pready || tmo_fire);
   assign cmd_ready = (st == IDLE) || done;
   assign accept    = cmd_valid && cmd_ready;
   assign state     = st;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         st          <= IDLE;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= '0;
         pprot       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;

         case (st)
            IDLE: ;
            SETUP: begin
               penable <= 1'b1;
               st      <= ACCESS;
            end
            ACCESS: begin
               if (done) begin
                  rsp_valid   <= 1'b1;
                  rsp_err     <= pready ? pslverr : 1'b1;
                  rsp_timeout <= !pready;
                  if (pready && !pwrite) begin
                     rsp_rdata <= prdata;
                  end
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  st      <= IDLE;
               end
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               st      <= IDLE;
            end
         endcase

         // A new command overrides the IDLE return of a finishing
         // transfer, giving back-to-back SETUP with psel held high.
         if (accept) begin
            paddr   <= cmd_addr;
            pwrite  <= cmd_write;
            pprot   <= cmd_prot;
            psel    <= 1'b1;
            penable <= 1'b0;
            st      <= SETUP;
            if (cmd_write) begin
               pwdata <= cmd_wdata;
               pstrb  <= cmd_strb;
            end else begin
               pstrb  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb4_master_ctrl.sv
// tb_apb4_master_ctrl: directed + random transfers checked
// cycle by cycle against a transfer-level timeline model.
module tb_apb4_master_ctrl;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 15;

   logic          pclk = 1'b0;
   logic          preset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_strb = '0;
   logic [2:0]    cmd_prot = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [2:0]    pprot;
   logic          pready = 1'b0;
   logic [DW-1:0] prdata = '0;
   logic          pslverr = 1'b0;
   logic [1:0]    state;

   apb4_master_ctrl #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TMO)
   ) dut (
      .pclk        (pclk),
      .preset      (preset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .cmd_prot    (cmd_prot),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .pprot       (pprot),
      .pready      (pready),
      .prdata      (prdata),
      .pslverr     (pslverr),
      .state       (state)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
      logic [2:0]    prot;
      int            waits;
      bit            serr;
      logic [DW-1:0] rdata;
      bit            b2b;
      int            gap;
   } xfer_t;

   xfer_t         q[$];
   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] last_wdata = '0;
   bit            rsp_pend = 1'b0;
   logic [DW-1:0] er_data;
   bit            er_err;
   bit            er_tmo;

   function automatic xfer_t mk(bit wr, logic [AW-1:0] a,
                                logic [DW-1:0] wd, logic [SW-1:0] s,
                                logic [2:0] p, int w, bit e,
                                logic [DW-1:0] rd, bit b, int g);
      xfer_t t;
      t.wr = wr; t.addr = a; t.wdata = wd; t.strb = s;
      t.prot = p; t.waits = w; t.serr = e; t.rdata = rd;
      t.b2b = b; t.gap = g;
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk_rsp();
      chk("rsp_valid", rsp_valid, rsp_pend);
      if (rsp_pend) begin
         chk("rsp_rdata", rsp_rdata, er_data);
         chk("rsp_err", rsp_err, er_err);
         chk("rsp_timeout", rsp_timeout, er_tmo);
      end
      rsp_pend = 1'b0;
   endtask

   task automatic chk_bus(input string ph, input bit ps, input bit pe,
                          input logic [1:0] st);
      chk({ph, "_psel"}, psel, ps);
      chk({ph, "_penable"}, penable, pe);
      chk({ph, "_state"}, state, st);
   endtask

   task automatic chk_ctrl(input xfer_t t);
      chk("paddr", paddr, t.addr);
      chk("pwrite", pwrite, t.wr);
      chk("pwdata", pwdata, last_wdata);
      chk("pstrb", pstrb, t.wr ? t.strb : '0);
      chk("pprot", pprot, t.prot);
   endtask

   task automatic drive_cmd(input xfer_t t);
      cmd_valid = 1'b1;
      cmd_write = t.wr;
      cmd_addr  = t.addr;
      cmd_wdata = t.wdata;
      cmd_strb  = t.strb;
      cmd_prot  = t.prot;
   endtask

   task automatic drive_junk();
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      cmd_strb  = SW'($urandom);
      cmd_prot  = 3'($urandom);
   endtask

   task automatic idle_cycle();
      step();
      pready  = 1'b0;
      pslverr = 1'b0;
      #1;
      chk_rsp();
      chk_bus("idle", 1'b0, 1'b0, 2'd0);
      chk("idle_cmd_ready", cmd_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bit nb;
      bit to;
      int e;
      int r;

      // Directed table, then random transfers.
      q.push_back(mk(1, 16'h0040, 32'hDEADBEEF, 4'hF, 3'b010,
                     0, 0, '0, 0, 1));
      q.push_back(mk(0, 16'h0100, 32'h0, 4'h0, 3'b000,
                     3, 0, 32'h12345678, 0, 1));
      q.push_back(mk(1, 16'h0010, 32'hA5A50001, 4'h3, 3'b001,
                     0, 0, '0, 0, 1));
      q.push_back(mk(0, 16'h0014, 32'h0, 4'h0, 3'b100,
                     0, 0, 32'hCAFE0014, 1, 0));
      q.push_back(mk(1, 16'h0020, 32'h11223344, 4'hC, 3'b000,
                     0, 1, '0, 0, 1));
      q.push_back(mk(0, 16'h0030, 32'h0, 4'h0, 3'b000,
                     99, 0, 32'h55AA55AA, 0, 1));
      q.push_back(mk(0, 16'h0034, 32'h0, 4'h0, 3'b000,
                     TMO, 0, 32'h0BADF00D, 0, 1));
      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 7);
         q.push_back(mk(1'($urandom), AW'($urandom), $urandom,
                        SW'($urandom), 3'($urandom),
                        (r < 5) ? r % 3 :
                        (r == 5) ? $urandom_range(3, TMO) : TMO + 1,
                        ($urandom_range(0, 3) == 0), $urandom,
                        1'($urandom), $urandom_range(1, 3)));
      end

      // Reset state
      #2 preset = 1'b1;
      #1;
      chk("rst_psel", psel, 1'b0);
      chk("rst_penable", penable, 1'b0);
      chk("rst_state", state, 2'd0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_paddr", paddr, '0);
      chk("rst_pstrb", pstrb, '0);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      step();
      step();
      preset = 1'b0;

      foreach (q[i]) begin
         if (!q[i].b2b) begin
            repeat (q[i].gap) idle_cycle();
         end
         drive_cmd(q[i]);
         #1;
         chk("accept_cmd_ready", cmd_ready, 1'b1);
         if (q[i].wr) last_wdata = q[i].wdata;

         // SETUP
         step();
         nb = (i + 1 < q.size()) && q[i+1].b2b;
         if (nb) drive_cmd(q[i+1]);
         else drive_junk();
         pready  = 1'($urandom);
         pslverr = 1'($urandom);
         prdata  = $urandom;
         #1;
         chk_rsp();
         chk_bus("setup", 1'b1, 1'b0, 2'd1);
         chk_ctrl(q[i]);
         chk("setup_cmd_ready", cmd_ready, 1'b0);

         // ACCESS: pready in cycle `waits`, or abort in cycle TMO
         to = q[i].waits > TMO;
         e  = to ? TMO : q[i].waits;
         for (int k = 0; k <= e; k++) begin
            step();
            pready  = (k == e) && !to;
            pslverr = (k == e) ? q[i].serr : 1'($urandom);
            prdata  = (k == e) ? q[i].rdata : $urandom;
            #1;
            chk_rsp();
            chk_bus("access", 1'b1, 1'b1, 2'd2);
            chk_ctrl(q[i]);
            chk("access_cmd_ready", cmd_ready, (k == e));
         end
         rsp_pend = 1'b1;
         er_data  = (!q[i].wr && !to) ? q[i].rdata : '0;
         er_err   = to || q[i].serr;
         er_tmo   = to;
      end
      idle_cycle();

      // Async reset in the middle of ACCESS
      drive_cmd(mk(1, 16'h0abc, 32'h87654321, 4'h5, 3'b011,
                   0, 0, '0, 0, 1));
      #1;
      step();
      drive_junk();
      step();
      pready = 1'b0;
      #1;
      chk_bus("pre_reset", 1'b1, 1'b1, 2'd2);
      #2 preset = 1'b1;
      #1;
      chk("mid_rst_psel", psel, 1'b0);
      chk("mid_rst_penable", penable, 1'b0);
      chk("mid_rst_state", state, 2'd0);
      chk("mid_rst_paddr", paddr, '0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      step();
      chk("in_rst_rsp_valid", rsp_valid, 1'b0);
      preset = 1'b0;
      #1;
      chk("post_rst_cmd_ready", cmd_ready, 1'b1);
      step();
      chk("post_rst_rsp_valid", rsp_valid, 1'b0);
      chk("post_rst_psel", psel, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
